// File: rtl/noc_hop_lookup_pkg.sv
// Shared sizing for the NoC hop-lookup stage, plus the slice helper used to
// pick one port's route table out of the packed ROUTE parameter.
`ifndef NOC_HOP_LOOKUP_BOUNDS_DEFINED
`define NOC_HOP_LOOKUP_BOUNDS_DEFINED
`define BOUNDS(i, w) ((i)*(w)) +: (w)
`endif

package noc_hop_lookup_pkg;

   // Number of switch output ports (one-hot select width).
   localparam int NEXTHOPWIDTH     = 32'sd4;
   // Destination address width.
   localparam int DESTWIDTH        = 32'sd4;
   // Route-table bits per port: one bit per reachable destination.
   localparam int ROUTE_WIRE_WIDTH = 32'sd2 ** DESTWIDTH;

endpackage : noc_hop_lookup_pkg

// File: rtl/noc_hop_lookup_ce_dff.sv
// Single-bit enabled D flop with asynchronous active-low clear. Every output
// bit of the hop-lookup stage sits in one of these, so the crossbar selects
// come straight from a flop with no logic after it.
module ce_dff (
   input  logic clk,
   input  logic rst,
   input  logic ce,
   input  logic d,
   output logic q
);

   logic q_d;
   logic q_q;

   // Load the new value on enable, otherwise recirculate the stored bit.
   always_comb begin
      if (ce) begin
         q_d = d;
      end else begin
         q_d = q_q;
      end
   end

   // State flop; the clear acts immediately, independent of clk and ce.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : ce_dff

// File: rtl/noc_hop_lookup.sv
// Registered next-hop select and look-ahead route stage at the output of a
// NoC switch input FIFO. On each FIFO read (ce) it captures the head flit's
// output-port select and, from a static per-port route table, the port the
// flit will use at the following switch. route_err flags a valid flit whose
// destination is served by no port.
module noc_hop_lookup #(
   parameter int NEXTHOPWIDTH     = noc_hop_lookup_pkg::NEXTHOPWIDTH,
   parameter int DESTWIDTH        = noc_hop_lookup_pkg::DESTWIDTH,
   parameter int ROUTE_WIRE_WIDTH = 32'sd2 ** DESTWIDTH,
   parameter logic [NEXTHOPWIDTH*ROUTE_WIRE_WIDTH-1:0] ROUTE =
      {NEXTHOPWIDTH*ROUTE_WIRE_WIDTH{1'b0}}
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ce,
   input  logic                    valid,
   input  logic [NEXTHOPWIDTH-1:0] nexthop,
   input  logic [DESTWIDTH-1:0]    destaddr,
   output logic [NEXTHOPWIDTH-1:0] sel,
   output logic [NEXTHOPWIDTH-1:0] to,
   output logic                    route_err
);

   // Full look-ahead vector, needed as a whole to detect "no route".
   logic [NEXTHOPWIDTH-1:0] to_d;
   logic                    route_err_d;

   for (genvar i = 0; i < NEXTHOPWIDTH; i++) begin : g_port
      logic [ROUTE_WIRE_WIDTH-1:0] route_slice;
      logic                        sel_bit_d;
      logic                        to_bit_d;

      // This port's table: bit d set means this port serves destination d.
      assign route_slice = ROUTE[`BOUNDS(i, ROUTE_WIRE_WIDTH)];

      // Per-port next state: gated select and plain table indexing (no arithmetic).
      always_comb begin
         sel_bit_d = nexthop[i] & valid;
         to_bit_d  = route_slice[destaddr];
      end

      assign to_d[i] = to_bit_d;

      ce_dff u_sel_ff (
         .clk (clk),
         .rst (rst),
         .ce  (ce),
         .d   (sel_bit_d),
         .q   (sel[i])
      );

      ce_dff u_to_ff (
         .clk (clk),
         .rst (rst),
         .ce  (ce),
         .d   (to_bit_d),
         .q   (to[i])
      );
   end : g_port

   // A valid flit whose destination no port serves is a route error.
   always_comb begin
      route_err_d = valid & ~(|to_d);
   end

   ce_dff u_err_ff (
      .clk (clk),
      .rst (rst),
      .ce  (ce),
      .d   (route_err_d),
      .q   (route_err)
   );

endmodule : noc_hop_lookup

// File: tb/tb_noc_hop_lookup.sv
// Self-checking bench for noc_hop_lookup in the 2-port / 2-bit-destination
// configuration. Two instances share all inputs: one with a complete route
// table and one with a hole (destination 3 unrouted).
module tb_noc_hop_lookup;

   localparam int          NHW     = 2;
   localparam int          DW      = 2;
   localparam logic [7:0]  ROUTE_A = 8'b1100_0011;
   localparam logic [7:0]  ROUTE_B = 8'b0100_0011;

   logic           clk;
   logic           rst;
   logic           ce;
   logic           valid;
   logic [NHW-1:0] nexthop;
   logic [DW-1:0]  destaddr;
   logic [NHW-1:0] sel_a, to_a, sel_b, to_b;
   logic           err_a, err_b;

   int compared = 0;
   int mismatched = 0;

   // Reference model state
   logic [NHW-1:0] exp_sel_a, exp_to_a, exp_sel_b, exp_to_b;
   logic           exp_err_a, exp_err_b;

   noc_hop_lookup #(.NEXTHOPWIDTH(NHW), .DESTWIDTH(DW), .ROUTE_WIRE_WIDTH(4), .ROUTE(ROUTE_A)) dut_a (
      .clk(clk), .rst(rst), .ce(ce), .valid(valid), .nexthop(nexthop),
      .destaddr(destaddr), .sel(sel_a), .to(to_a), .route_err(err_a));

   noc_hop_lookup #(.NEXTHOPWIDTH(NHW), .DESTWIDTH(DW), .ROUTE_WIRE_WIDTH(4), .ROUTE(ROUTE_B)) dut_b (
      .clk(clk), .rst(rst), .ce(ce), .valid(valid), .nexthop(nexthop),
      .destaddr(destaddr), .sel(sel_b), .to(to_b), .route_err(err_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Which ports serve destination `dest`: port p owns table bits p*4 .. p*4+3.
   function automatic logic [NHW-1:0] ports_serving(input logic [7:0] table_bits, input int dest);
      logic [NHW-1:0] r;
      r = '0;
      for (int p = 0; p < NHW; p++) begin
         r[p] = ((table_bits >> (p * 4 + dest)) & 8'd1) != 8'd0;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".sel_a"}, {6'd0, sel_a}, {6'd0, exp_sel_a});
      chk({tag, ".to_a"},  {6'd0, to_a},  {6'd0, exp_to_a});
      chk({tag, ".err_a"}, {7'd0, err_a}, {7'd0, exp_err_a});
      chk({tag, ".sel_b"}, {6'd0, sel_b}, {6'd0, exp_sel_b});
      chk({tag, ".to_b"},  {6'd0, to_b},  {6'd0, exp_to_b});
      chk({tag, ".err_b"}, {7'd0, err_b}, {7'd0, exp_err_b});
   endtask

   task automatic model_clear();
      exp_sel_a = '0; exp_to_a = '0; exp_err_a = 1'b0;
      exp_sel_b = '0; exp_to_b = '0; exp_err_b = 1'b0;
   endtask

   // One rising edge; inputs are stable across it, so the model uses them directly.
   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         model_clear();
      end else if (ce) begin
         exp_sel_a = valid ? nexthop : '0;
         exp_sel_b = exp_sel_a;
         exp_to_a  = ports_serving(ROUTE_A, int'(destaddr));
         exp_to_b  = ports_serving(ROUTE_B, int'(destaddr));
         exp_err_a = valid && (exp_to_a == '0);
         exp_err_b = valid && (exp_to_b == '0);
      end
      #1;
   endtask

   task automatic drive(input logic c, input logic v, input logic [NHW-1:0] nh, input logic [DW-1:0] d);
      ce = c; valid = v; nexthop = nh; destaddr = d;
   endtask

   initial begin
      model_clear();
      drive(1'b0, 1'b0, 2'b00, 2'd0);
      rst = 1'b0;

      // 1: reset held with random activity
      for (int k = 0; k < 4; k++) begin
         drive(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom));
         tick();
         check_all("reset_hold");
      end
      drive(1'b0, 1'b1, 2'b11, 2'd2);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_all("post_reset_no_ce");
      end

      // 2: capture
      drive(1'b1, 1'b1, 2'b01, 2'd2);
      tick();
      check_all("capture1");
      chk("capture1.sel_const", {6'd0, sel_a}, 8'h01);
      chk("capture1.to_const",  {6'd0, to_a},  8'h02);
      drive(1'b1, 1'b1, 2'b10, 2'd1);
      tick();
      check_all("capture2");
      chk("capture2.sel_const", {6'd0, sel_a}, 8'h02);
      chk("capture2.to_const",  {6'd0, to_a},  8'h01);

      // 3: hold with ce low
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'($urandom), 2'($urandom), 2'($urandom));
         tick();
         check_all("hold");
         chk("hold.sel_const", {6'd0, sel_a}, 8'h02);
      end

      // 4: empty FIFO
      drive(1'b1, 1'b0, 2'b01, 2'd3);
      tick();
      check_all("empty");
      chk("empty.to_const", {6'd0, to_a}, 8'h02);

      // 5: no route (instance b has no port for destination 3)
      drive(1'b1, 1'b1, 2'b01, 2'd3);
      tick();
      check_all("noroute");
      chk("noroute.to_b_const",  {6'd0, to_b},  8'h00);
      chk("noroute.err_b_const", {7'd0, err_b}, 8'h01);
      chk("noroute.err_a_const", {7'd0, err_a}, 8'h00);

      // 6: asynchronous reset between edges
      drive(1'b1, 1'b1, 2'b01, 2'd0);
      tick();
      check_all("pre_async");
      chk("pre_async.sel_const", {6'd0, sel_a}, 8'h01);
      ce = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      model_clear();
      check_all("async_clear");
      #1;
      rst = 1'b1;
      tick();
      check_all("after_async");

      // 7: randomized traffic against the model, with occasional resets
      for (int k = 0; k < 300; k++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), 2'($urandom));
         rst = ($urandom_range(0, 40) != 0);
         tick();
         check_all("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_noc_hop_lookup
